// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
// Included by the arbiter top level and by its outstanding-read ID FIFO.
package mem_arb_pkg;

   typedef enum logic {
      SRC_IRAM = 1'b0,
      SRC_DRAM = 1'b1
   } arb_src_e;

   localparam int XLEN_DEF       = 32;
   localparam int OSTD_DEPTH_DEF = 4;
   localparam int OSTD_AW        = $clog2(OSTD_DEPTH_DEF);

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of source IDs for reads issued on the shared bus.
// Pointers carry an extra wrap bit, which lets full and empty be told apart.
module arb_id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = OSTD_DEPTH_DEF
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  arb_src_e push_id,
   input  logic     pop,
   output arb_src_e head_id,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   arb_src_e       mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_id = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; an entry is only read after a push has written it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter letting the instruction and data ports share one memory bus.
// Grants are held while the bus stalls; read responses are routed back in issue order.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int OSTD_DEPTH   = OSTD_DEPTH_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              iram_req,
   input  logic              iram_write,
   input  logic [XLEN/8-1:0] iram_wstrb,
   input  logic [XLEN-1:0]   iram_addr,
   input  logic [XLEN-1:0]   iram_wdata,
   output logic              iram_ready,
   output logic              iram_rvalid,
   output logic [XLEN-1:0]   iram_rdata,

   input  logic              dram_req,
   input  logic              dram_write,
   input  logic [XLEN/8-1:0] dram_wstrb,
   input  logic [XLEN-1:0]   dram_addr,
   input  logic [XLEN-1:0]   dram_wdata,
   output logic              dram_ready,
   output logic              dram_rvalid,
   output logic [XLEN-1:0]   dram_rdata,

   output logic              bus_req,
   output logic              bus_write,
   output logic [XLEN/8-1:0] bus_wstrb,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   input  logic              bus_ready,
   input  logic              bus_rvalid,
   input  logic [XLEN-1:0]   bus_rdata,

   output logic              err_rvalid
);

   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   logic              lock_q;
   arb_src_e          lock_src_q;
   logic [SW-1:0]     starve_q;
   logic              err_q;

   logic              sel_req;
   arb_src_e          sel_src;
   logic              sel_write;
   logic [XLEN/8-1:0] sel_wstrb;
   logic [XLEN-1:0]   sel_addr;
   logic [XLEN-1:0]   sel_wdata;

   logic              present;
   logic              xfer;
   logic              fifo_full;
   logic              fifo_empty;
   arb_src_e          head_id;
   logic              rsp_ok;

   // Source selection: a stalled grant stays put, otherwise data wins until starvation.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      sel_req = 1'b0;
      sel_src = SRC_IRAM;
      if (lock_q) begin
         sel_src = lock_src_q;
         sel_req = (lock_src_q == SRC_DRAM) ? dram_req : iram_req;
      end else if (dram_req && (starve_q < STARVE_MAX)) begin
         sel_src = SRC_DRAM;
         sel_req = 1'b1;
      end else if (iram_req) begin
         sel_src = SRC_IRAM;
         sel_req = 1'b1;
      end else if (dram_req) begin
         sel_src = SRC_DRAM;
         sel_req = 1'b1;
      end
   end

   always_comb begin
      sel_write = 1'b0;
      sel_wstrb = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (sel_req) begin
         if (sel_src == SRC_DRAM) begin
            sel_write = dram_write;
            sel_wstrb = dram_wstrb;
            sel_addr  = dram_addr;
            sel_wdata = dram_wdata;
         end else begin
            sel_write = iram_write;
            sel_wstrb = iram_wstrb;
            sel_addr  = iram_addr;
            sel_wdata = iram_wdata;
         end
      end
   end

   // Reads wait while every outstanding slot is taken; a same-cycle pop does not count.
   assign present    = sel_req && (sel_write || !fifo_full) && !rst;
   assign xfer       = present && bus_ready;

   assign bus_req    = present;
   assign bus_write  = sel_write;
   assign bus_wstrb  = sel_wstrb;
   assign bus_addr   = sel_addr;
   assign bus_wdata  = sel_wdata;

   assign iram_ready = xfer && (sel_src == SRC_IRAM);
   assign dram_ready = xfer && (sel_src == SRC_DRAM);

   assign rsp_ok      = bus_rvalid && !fifo_empty && !rst;
   assign iram_rvalid = rsp_ok && (head_id == SRC_IRAM);
   assign dram_rvalid = rsp_ok && (head_id == SRC_DRAM);
   assign iram_rdata  = bus_rdata;
   assign dram_rdata  = bus_rdata;
   assign err_rvalid  = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q     <= 1'b0;
         lock_src_q <= SRC_IRAM;
         starve_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         lock_q <= present && !bus_ready;
         if (present) lock_src_q <= sel_src;

         if (!iram_req || (xfer && (sel_src == SRC_IRAM))) begin
            starve_q <= '0;
         end else if (xfer && (sel_src == SRC_DRAM) && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + 1'b1;
         end

         err_q <= bus_rvalid && fifo_empty;
      end
   end

   arb_id_fifo #(
      .DEPTH   (OSTD_DEPTH)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (xfer && !sel_write),
      .push_id (sel_src),
      .pop     (rsp_ok),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule
